// File: rtl/act_lut_load_ctrl.sv
// Loader/arbiter for the 4096x16 sigmoid/tanh LUT RAM: streams a new table in,
// then hands the single RAM port to the cell for reads.
module act_lut_load_ctrl #(
   parameter int LUT_DEPTH      = 4096,
   parameter int LUT_ADDR_WIDTH = 12,
   parameter int LUT_DATA_WIDTH = 16
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      load_start,
   input  logic [2:0]                load_type,
   input  logic [LUT_DATA_WIDTH-1:0] s_lut_data,
   input  logic                      s_lut_valid,
   input  logic                      s_lut_last,
   output logic                      s_lut_ready,
   input  logic                      cell_ren,
   input  logic [LUT_ADDR_WIDTH-1:0] cell_addr,
   output logic [LUT_DATA_WIDTH-1:0] cell_dout,
   output logic                      mem_en,
   output logic                      mem_wen,
   output logic [LUT_ADDR_WIDTH-1:0] mem_addr,
   output logic [LUT_DATA_WIDTH-1:0] mem_din,
   input  logic [LUT_DATA_WIDTH-1:0] mem_dout,
   output logic                      lut_vld,
   output logic [2:0]                lut_type,
   output logic                      load_busy,
   output logic                      load_done,
   output logic                      err_short,
   output logic                      err_long,
   output logic                      rd_drop
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READY} state_t;

   localparam logic [LUT_ADDR_WIDTH-1:0] CNT_LAST = LUT_ADDR_WIDTH'(LUT_DEPTH - 1);

   state_t                    state_q, state_d;
   logic [LUT_ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]                type_q, type_d;
   logic                      err_short_q, err_short_d;
   logic                      err_long_q, err_long_d;
   logic                      rd_drop_q, rd_drop_d;
   logic                      load_done_q, load_done_d;
   logic                      hs;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         type_q      <= 3'b111;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         rd_drop_q   <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         type_q      <= type_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         rd_drop_q   <= rd_drop_d;
         load_done_q <= load_done_d;
      end
   end

   assign s_lut_ready = (state_q == LOAD) || (state_q == DRAIN);
   assign hs          = s_lut_valid & s_lut_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      type_d      = type_q;
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
      rd_drop_d   = rd_drop_q;
      load_done_d = 1'b0;
      case (state_q)
         IDLE, READY: begin
            if (load_start) begin
               state_d     = LOAD;
               cnt_d       = '0;
               type_d      = load_type;
               err_short_d = 1'b0;
               err_long_d  = 1'b0;
            end
         end
         LOAD: begin
            if (hs) begin
               cnt_d = cnt_q + 1'b1;
               if (s_lut_last) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d     = READY;
                     load_done_d = 1'b1;
                  end else begin
                     state_d     = IDLE;
                     err_short_d = 1'b1;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Overflow beats are swallowed; the first LUT_DEPTH words stay in RAM.
            if (hs && s_lut_last) begin
               state_d     = READY;
               err_long_d  = 1'b1;
               load_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_done_d) rd_drop_d = 1'b0;
      if (cell_ren && state_q != READY) rd_drop_d = 1'b1;
   end

   // Single RAM port: loader owns it in LOAD, cell owns it in READY.
   always_comb begin
      mem_en   = 1'b0;
      mem_wen  = 1'b0;
      mem_addr = cnt_q;
      mem_din  = s_lut_data;
      case (state_q)
         LOAD: begin
            mem_en  = hs;
            mem_wen = hs;
         end
         READY: begin
            mem_en   = cell_ren;
            mem_addr = cell_addr;
         end
         default: ;
      endcase
   end

   assign cell_dout = mem_dout;
   assign lut_vld   = (state_q == READY);
   assign lut_type  = type_q;
   assign load_busy = s_lut_ready;
   assign load_done = load_done_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;
   assign rd_drop   = rd_drop_q;

endmodule

// File: tb/tb_act_lut_load_ctrl.sv
// Bench for act_lut_load_ctrl: behavioural RAM plus a table model built from the
// beats sent, with random data, valid gaps and random cell reads.
module tb_act_lut_load_ctrl;

   localparam int DEPTH = 4096;

   logic        aclk = 1'b0;
   logic        areset;
   logic        load_start;
   logic [2:0]  load_type;
   logic [15:0] s_lut_data;
   logic        s_lut_valid;
   logic        s_lut_last;
   logic        s_lut_ready;
   logic        cell_ren;
   logic [11:0] cell_addr;
   logic [15:0] cell_dout;
   logic        mem_en;
   logic        mem_wen;
   logic [11:0] mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout;
   logic        lut_vld;
   logic [2:0]  lut_type;
   logic        load_busy;
   logic        load_done;
   logic        err_short;
   logic        err_long;
   logic        rd_drop;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] ram   [0:DEPTH-1];
   logic [15:0] tbl   [0:DEPTH-1];
   bit          known [0:DEPTH-1];
   logic [15:0] sent  [0:DEPTH+15];
   int          wr_cnt = 0;
   int          bad_wr = 0;
   int          wr_base = 0;
   int          bad_base = 0;

   act_lut_load_ctrl dut (
      .aclk(aclk), .areset(areset), .load_start(load_start), .load_type(load_type),
      .s_lut_data(s_lut_data), .s_lut_valid(s_lut_valid), .s_lut_last(s_lut_last),
      .s_lut_ready(s_lut_ready), .cell_ren(cell_ren), .cell_addr(cell_addr),
      .cell_dout(cell_dout), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .lut_vld(lut_vld), .lut_type(lut_type),
      .load_busy(load_busy), .load_done(load_done), .err_short(err_short),
      .err_long(err_long), .rd_drop(rd_drop)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (mem_en && mem_wen) ram[mem_addr] <= mem_din;
      else if (mem_en) mem_dout <= ram[mem_addr];
   end

   // Every write must land on the next contiguous address of the current load.
   always @(negedge aclk) begin
      if (mem_en && mem_wen) begin
         if (mem_addr != 12'(wr_cnt - wr_base)) bad_wr++;
         wr_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic start_load(input logic [2:0] t);
      load_start = 1'b1;
      load_type  = t;
      wr_base    = wr_cnt;
      bad_base   = bad_wr;
      tick();
      load_start = 1'b0;
      load_type  = 3'($urandom);
      chk("start_ready", s_lut_ready, 1);
      chk("start_busy", load_busy, 1);
   endtask

   // Sends beats 0..n-1 of sent[]; last flagged on beat last_at. cyc = cycles used.
   task automatic stream(input int n, input int last_at, input bit gaps, input bit pulse,
                         output int cyc);
      int  i = 0;
      bit  v, hs, pdone = 0;
      cyc = 0;
      while (i < n && cyc < n * 4 + 20) begin
         v           = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_lut_valid = v;
         s_lut_data  = sent[i];
         s_lut_last  = (i == last_at);
         load_start  = pulse && i == 10 && !pdone;
         if (load_start) begin
            load_type = 3'b100;
            pdone     = 1;
         end
         #1;
         hs = v && s_lut_ready;
         tick();
         cyc++;
         if (hs) i++;
      end
      s_lut_valid = 1'b0;
      s_lut_last  = 1'b0;
      load_start  = 1'b0;
      chk("stream_beats", i, n);
   endtask

   // Model: the first min(beats, DEPTH) beats become table words 0.. in order.
   task automatic end_load(input string tag, input int beats);
      int w = (beats < DEPTH) ? beats : DEPTH;
      int m = 0;
      chk({tag, "_wr_cnt"}, wr_cnt - wr_base, w);
      chk({tag, "_wr_contig"}, bad_wr - bad_base, 0);
      for (int k = 0; k < w; k++) begin
         tbl[k]   = sent[k];
         known[k] = 1;
      end
      for (int k = 0; k < DEPTH; k++)
         if (known[k] && ram[k] !== tbl[k]) m++;
      chk({tag, "_ram"}, m, 0);
   endtask

   task automatic fill_random(input int n);
      for (int k = 0; k < n; k++) sent[k] = 16'($urandom);
   endtask

   initial begin
      int          cyc;
      logic [11:0] a;
      areset = 1'b1; load_start = 0; load_type = 0; s_lut_data = 0; s_lut_valid = 0;
      s_lut_last = 0; cell_ren = 0; cell_addr = 0;
      for (int k = 0; k < DEPTH; k++) known[k] = 0;
      tick(); tick();
      areset = 1'b0;
      chk("rst_ready", s_lut_ready, 0);
      chk("rst_vld", lut_vld, 0);
      chk("rst_type", lut_type, 3'b111);
      chk("rst_flags", {load_busy, load_done, err_short, err_long, rd_drop}, 0);

      // Full back-to-back load, data = address.
      for (int k = 0; k < DEPTH; k++) sent[k] = 16'(k);
      start_load(3'b001);
      stream(DEPTH, DEPTH - 1, 0, 0, cyc);
      chk("t1_cycles", cyc + 1, DEPTH + 1);
      chk("t1_vld", lut_vld, 1);
      chk("t1_done", load_done, 1);
      chk("t1_type", lut_type, 3'b001);
      end_load("t1", DEPTH);
      tick();
      chk("t1_done_pulse", load_done, 0);

      // Cell reads in READY.
      cell_ren = 1'b1; cell_addr = 12'h7FF;
      #1;
      chk("t2_port", {mem_en, mem_wen, mem_addr}, {1'b1, 1'b0, 12'h7FF});
      tick();
      chk("t2_dout", cell_dout, 16'h07FF);
      for (int k = 0; k < 8; k++) begin
         a = 12'($urandom);
         cell_addr = a;
         tick();
         chk("t2_rand_rd", cell_dout, tbl[a]);
      end
      cell_ren = 1'b0;

      // Gappy stream with an ignored mid-load load_start.
      fill_random(DEPTH);
      start_load(3'b010);
      stream(DEPTH, DEPTH - 1, 1, 1, cyc);
      chk("t3_vld_done", {lut_vld, load_done}, 2'b11);
      chk("t3_type", lut_type, 3'b010);
      end_load("t3", DEPTH);

      // Short table.
      fill_random(101);
      start_load(3'b001);
      stream(101, 100, 1, 0, cyc);
      chk("t4_state", {lut_vld, load_busy, load_done, err_short, err_long}, 5'b00010);
      chk("t4_type", lut_type, 3'b001);
      end_load("t4", 101);
      cell_ren = 1'b1; cell_addr = 12'h005;
      #1;
      chk("t4_mem_en", mem_en, 0);
      tick();
      cell_ren = 1'b0;
      chk("t4_rd_drop", rd_drop, 1);

      // Overlong table: extra beats drained.
      fill_random(DEPTH + 4);
      start_load(3'b010);
      chk("t5_err_clr", {err_short, rd_drop}, 2'b01);
      stream(DEPTH + 4, DEPTH + 3, 0, 1, cyc);
      chk("t5_state", {lut_vld, load_done, err_short, err_long, rd_drop}, 5'b11010);
      chk("t5_type", lut_type, 3'b010);
      end_load("t5", DEPTH + 4);

      // load_start with a same-cycle read, then reset mid-load.
      a = 12'($urandom);
      load_start = 1'b1; load_type = 3'b001; cell_ren = 1'b1; cell_addr = a;
      wr_base = wr_cnt; bad_base = bad_wr;
      #1;
      chk("t6_port", {mem_en, mem_wen, mem_addr}, {1'b1, 1'b0, a});
      tick();
      load_start = 1'b0; cell_ren = 1'b0;
      chk("t6_ready_vld", {s_lut_ready, lut_vld}, 2'b10);
      chk("t6_dout", cell_dout, tbl[a]);
      cell_ren = 1'b1;
      tick();
      cell_ren = 1'b0;
      chk("t6_rd_drop", rd_drop, 1);
      fill_random(50);
      stream(50, 1000, 1, 0, cyc);
      chk("t6_busy", load_busy, 1);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      chk("t6_rst_vld", lut_vld, 0);
      chk("t6_rst_type", lut_type, 3'b111);
      chk("t6_rst_flags", {s_lut_ready, load_busy, load_done, err_short, err_long, rd_drop}, 0);
      end_load("t6", 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
